regfile_write_arbiter: RTL and testbench

// Shares the single register-bank write port between three writers: the multicycle CPU

---
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Purpose : shares the register-bank write port between CPU writeback, the IO unit and the debug/loader port.
// Latency : 1 cycle from winning request to the registered bank write and the one-cycle ack pulse.
// Backpressure: CPU always wins but gets a one-cycle oCpuStall when an IO/DBG request starves; IO/DBG hold req until ack.
//
// Ports:
//   iCLK, iCLR                      clock / async active-low reset
//   iCpuWe, iCpuReg, iCpuData       CPU single-cycle write strobe (no handshake)
//   oCpuStall                       CPU must not write this cycle
//   iIoReq, iIoReg, iIoData, oIoAck     IO request held until one-cycle ack
//   iDbgReq, iDbgReg, iDbgData, oDbgAck debug request, same contract as IO
//   oRegWrite, oWriteRegister, oWriteData  registered bank write port
//   oErr                            sticky flag: CPU wrote during a stall cycle
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic              iCLK,
  input  logic              iCLR,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuReg,
  input  logic [DATA_W-1:0] iCpuData,
  output logic              oCpuStall,
  input  logic              iIoReq,
  input  logic [ADDR_W-1:0] iIoReg,
  input  logic [DATA_W-1:0] iIoData,
  output logic              oIoAck,
  input  logic              iDbgReq,
  input  logic [ADDR_W-1:0] iDbgReg,
  input  logic [DATA_W-1:0] iDbgData,
  output logic              oDbgAck,
  output logic              oRegWrite,
  output logic [ADDR_W-1:0] oWriteRegister,
  output logic [DATA_W-1:0] oWriteData,
  output logic              oErr
);

  localparam int            CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WTRIG = CW'(MAX_WAIT - 1);

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_io_ack;
  logic              r_dbg_ack;
  logic              r_cpu_stall;
  logic              r_err;
  logic [CW-1:0]     r_io_wait;
  logic [CW-1:0]     r_dbg_wait;
  logic              r_prefer_dbg;   // 0: IO wins a tie, 1: DBG wins a tie

  logic              w_io_elig;
  logic              w_dbg_elig;
  logic              w_cpu_win;
  logic              w_io_win;
  logic              w_dbg_win;
  logic              w_any_win;
  logic [ADDR_W-1:0] w_win_reg;
  logic [DATA_W-1:0] w_win_data;
  logic              w_io_blocked;
  logic              w_dbg_blocked;
  logic              w_starve;
  logic [CW-1:0]     w_io_wait_nxt;
  logic [CW-1:0]     w_dbg_wait_nxt;

  // A request whose ack is high is in its hold cycle and must not be granted again.
  assign w_io_elig  = iIoReq  && !r_io_ack;
  assign w_dbg_elig = iDbgReq && !r_dbg_ack;

  // A CPU write during a stall cycle is dropped, so the RR winner owns the port then.
  assign w_cpu_win = iCpuWe && !r_cpu_stall;
  assign w_io_win  = !w_cpu_win && w_io_elig  && (!w_dbg_elig || !r_prefer_dbg);
  assign w_dbg_win = !w_cpu_win && w_dbg_elig && (!w_io_elig  ||  r_prefer_dbg);
  assign w_any_win = w_cpu_win || w_io_win || w_dbg_win;

  always_comb begin
    w_win_reg  = iCpuReg;
    w_win_data = iCpuData;
    if (w_io_win) begin
      w_win_reg  = iIoReg;
      w_win_data = iIoData;
    end else if (w_dbg_win) begin
      w_win_reg  = iDbgReg;
      w_win_data = iDbgData;
    end
  end

  assign w_io_blocked  = w_io_elig  && !w_io_win;
  assign w_dbg_blocked = w_dbg_elig && !w_dbg_win;

  always_comb begin
    w_io_wait_nxt = r_io_wait;
    if (!iIoReq || w_io_win)
      w_io_wait_nxt = '0;
    else if (w_io_blocked && r_io_wait != WMAX)
      w_io_wait_nxt = r_io_wait + CW'(1);
  end

  always_comb begin
    w_dbg_wait_nxt = r_dbg_wait;
    if (!iDbgReq || w_dbg_win)
      w_dbg_wait_nxt = '0;
    else if (w_dbg_blocked && r_dbg_wait != WMAX)
      w_dbg_wait_nxt = r_dbg_wait + CW'(1);
  end

  // Stall when a blocked counter climbs to (or sits at) MAX_WAIT. Suppressed while a
  // stall is already showing, so a second starving requester gets its own, later stall.
  assign w_starve = !r_cpu_stall &&
                    ((w_io_blocked  && r_io_wait  >= WTRIG) ||
                     (w_dbg_blocked && r_dbg_wait >= WTRIG));

  always_ff @(posedge iCLK or negedge iCLR) begin
    if (!iCLR) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_io_ack     <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_cpu_stall  <= 1'b0;
      r_err        <= 1'b0;
      r_io_wait    <= '0;
      r_dbg_wait   <= '0;
      r_prefer_dbg <= 1'b0;
    end else begin
      // Register 0 is never written but the grant (and ack) still happens.
      r_reg_write <= w_any_win && (w_win_reg != '0);
      if (w_any_win) begin
        r_write_reg  <= w_win_reg;
        r_write_data <= w_win_data;
      end
      r_io_ack    <= w_io_win;
      r_dbg_ack   <= w_dbg_win;
      r_cpu_stall <= w_starve;
      if (iCpuWe && r_cpu_stall)
        r_err <= 1'b1;
      r_io_wait  <= w_io_wait_nxt;
      r_dbg_wait <= w_dbg_wait_nxt;
      if (w_io_win)
        r_prefer_dbg <= 1'b1;
      else if (w_dbg_win)
        r_prefer_dbg <= 1'b0;
    end
  end

  assign oRegWrite      = r_reg_write;
  assign oWriteRegister = r_write_reg;
  assign oWriteData     = r_write_data;
  assign oIoAck         = r_io_ack;
  assign oDbgAck        = r_dbg_ack;
  assign oCpuStall      = r_cpu_stall;
  assign oErr           = r_err;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose : self-checking bench for regfile_write_arbiter (directed cases plus randomized traffic).
// Latency : reference model produces the expected registered outputs one edge after the inputs.
// Backpressure: bench requesters hold req until ack and the CPU honours oCpuStall except where a violation is intended.
module tb_regfile_write_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 8;

  logic              iCLK = 1'b0;
  logic              iCLR = 1'b0;
  logic              iCpuWe = 1'b0;
  logic [ADDR_W-1:0] iCpuReg = '0;
  logic [DATA_W-1:0] iCpuData = '0;
  logic              oCpuStall;
  logic              iIoReq = 1'b0;
  logic [ADDR_W-1:0] iIoReg = '0;
  logic [DATA_W-1:0] iIoData = '0;
  logic              oIoAck;
  logic              iDbgReq = 1'b0;
  logic [ADDR_W-1:0] iDbgReg = '0;
  logic [DATA_W-1:0] iDbgData = '0;
  logic              oDbgAck;
  logic              oRegWrite;
  logic [ADDR_W-1:0] oWriteRegister;
  logic [DATA_W-1:0] oWriteData;
  logic              oErr;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .iCLK(iCLK), .iCLR(iCLR),
    .iCpuWe(iCpuWe), .iCpuReg(iCpuReg), .iCpuData(iCpuData), .oCpuStall(oCpuStall),
    .iIoReq(iIoReq), .iIoReg(iIoReg), .iIoData(iIoData), .oIoAck(oIoAck),
    .iDbgReq(iDbgReq), .iDbgReg(iDbgReg), .iDbgData(iDbgData), .oDbgAck(oDbgAck),
    .oRegWrite(oRegWrite), .oWriteRegister(oWriteRegister), .oWriteData(oWriteData),
    .oErr(oErr)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: requester index 0 = IO, 1 = DBG, 2 = CPU.
  int          m_wait[2];
  int          m_last;        // last IO/DBG requester granted
  bit          m_ack[2];
  bit          m_we;
  bit          m_stall;
  bit          m_err;
  int          m_addr;
  logic [31:0] m_data;

  function automatic void model_reset();
    m_wait[0] = 0; m_wait[1] = 0;
    m_last = 1;               // so that IO is the first preferred
    m_ack[0] = 0; m_ack[1] = 0;
    m_we = 0; m_stall = 0; m_err = 0;
    m_addr = 0; m_data = '0;
  endfunction

  function automatic void model_step();
    bit          req[2];
    int          rg[2];
    logic [31:0] dt[2];
    bit          elig[2];
    int          win;
    bit          starve;
    int          a;
    logic [31:0] d;
    req[0] = iIoReq;  rg[0] = int'(iIoReg);  dt[0] = iIoData;
    req[1] = iDbgReq; rg[1] = int'(iDbgReg); dt[1] = iDbgData;
    for (int r = 0; r < 2; r++) elig[r] = req[r] && !m_ack[r];
    win = -1;
    if (iCpuWe && !m_stall)      win = 2;
    else if (elig[0] && elig[1]) win = 1 - m_last;
    else if (elig[0])            win = 0;
    else if (elig[1])            win = 1;
    starve = 0;
    for (int r = 0; r < 2; r++)
      if (elig[r] && win != r && m_wait[r] + 1 >= MAX_WAIT) starve = 1;
    if (iCpuWe && m_stall) m_err = 1;
    for (int r = 0; r < 2; r++) begin
      if (!req[r] || win == r) m_wait[r] = 0;
      else if (elig[r] && m_wait[r] < MAX_WAIT) m_wait[r] = m_wait[r] + 1;
      m_ack[r] = (win == r);
    end
    if (win == 0 || win == 1) m_last = win;
    if (win >= 0) begin
      if (win == 2) begin a = int'(iCpuReg); d = iCpuData; end
      else begin a = rg[win]; d = dt[win]; end
      m_we = (a != 0); m_addr = a; m_data = d;
    end else begin
      m_we = 0;
    end
    m_stall = starve && !m_stall;
  endfunction

  always @(posedge iCLK or negedge iCLR) begin
    if (!iCLR) model_reset();
    else       model_step();
  end

  task automatic compare_all();
    check("regwrite", 64'(oRegWrite), 64'(m_we));
    check("wreg", 64'(oWriteRegister), 64'(m_addr));
    check("wdata", 64'(oWriteData), 64'(m_data));
    check("ioack", 64'(oIoAck), 64'(m_ack[0]));
    check("dbgack", 64'(oDbgAck), 64'(m_ack[1]));
    check("stall", 64'(oCpuStall), 64'(m_stall));
    check("err", 64'(oErr), 64'(m_err));
  endtask

  task automatic step();
    @(negedge iCLK);
    compare_all();
  endtask

  bit seen[2];

  task automatic set_req(input int r, input logic v, input logic [ADDR_W-1:0] rg, input logic [DATA_W-1:0] d);
    if (r == 0) begin iIoReq = v; iIoReg = rg; iIoData = d; end
    else begin iDbgReq = v; iDbgReg = rg; iDbgData = d; end
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iCLR = 1'b0;
    iCpuWe = 1'b0; set_req(0, 1'b0, '0, '0); set_req(1, 1'b0, '0, '0);
    seen[0] = 0; seen[1] = 0;
    step();
    check("rst_regwrite", 64'(oRegWrite), 64'd0);
    check("rst_wreg", 64'(oWriteRegister), 64'd0);
    check("rst_wdata", 64'(oWriteData), 64'd0);
    check("rst_ioack", 64'(oIoAck), 64'd0);
    check("rst_dbgack", 64'(oDbgAck), 64'd0);
    check("rst_stall", 64'(oCpuStall), 64'd0);
    check("rst_err", 64'(oErr), 64'd0);
    iCLR = 1'b1;
  endtask

  // IO starves behind a CPU writing every cycle; optionally the CPU ignores the stall.
  task automatic run_starve(input bit violate);
    do_reset();
    set_req(0, 1'b1, 5'd4, 32'h1234_5678);
    iCpuWe = 1'b1; iCpuReg = 5'd9; iCpuData = 32'h0000_0900;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("starve_nostall", 64'(oCpuStall), 64'd0);
      iCpuData = 32'h0000_0900 + 32'(k);
    end
    step();
    check("starve_stall", 64'(oCpuStall), 64'd1);
    check("starve_cpuw_reg", 64'(oWriteRegister), 64'd9);
    iCpuWe = violate;
    step();
    check("starve_io_we", 64'(oRegWrite), 64'd1);
    check("starve_io_reg", 64'(oWriteRegister), 64'd4);
    check("starve_io_data", 64'(oWriteData), 64'h1234_5678);
    check("starve_io_ack", 64'(oIoAck), 64'd1);
    check("starve_stall_clr", 64'(oCpuStall), 64'd0);
    check("starve_err", 64'(oErr), 64'(violate));
    iCpuWe = 1'b0;
    step();
    set_req(0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("starve_err_sticky", 64'(oErr), 64'(violate));
    end
  endtask

  task automatic rand_cycle(input int cpu_pct, input int req_pct);
    logic cur;
    step();
    iCpuWe   = !m_stall && ($urandom_range(99) < 32'(cpu_pct));
    iCpuReg  = ADDR_W'($urandom_range(31));
    iCpuData = $urandom;
    for (int r = 0; r < 2; r++) begin
      cur = (r == 0) ? iIoReq : iDbgReq;
      if (m_ack[r]) begin
        seen[r] = 1'b1;
      end else if (seen[r] || !cur) begin
        seen[r] = 1'b0;
        set_req(r, $urandom_range(99) < 32'(req_pct), ADDR_W'($urandom_range(31)), $urandom);
      end
    end
  endtask

  initial begin
    model_reset();
    seen[0] = 0; seen[1] = 0;

    // T1: plain CPU write
    do_reset();
    iCpuWe = 1'b1; iCpuReg = 5'd8; iCpuData = 32'hA5;
    step();
    check("t1_we", 64'(oRegWrite), 64'd1);
    check("t1_reg", 64'(oWriteRegister), 64'd8);
    check("t1_data", 64'(oWriteData), 64'hA5);
    check("t1_ioack", 64'(oIoAck), 64'd0);
    check("t1_dbgack", 64'(oDbgAck), 64'd0);
    iCpuWe = 1'b0;
    step();
    check("t1_we_off", 64'(oRegWrite), 64'd0);
    check("t1_reg_hold", 64'(oWriteRegister), 64'd8);

    // T2: IO and DBG together, IO first then DBG
    do_reset();
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(1, 1'b1, 5'd5, 32'h55);
    step();
    check("t2_ioack1", 64'(oIoAck), 64'd1);
    check("t2_dbgack1", 64'(oDbgAck), 64'd0);
    check("t2_reg1", 64'(oWriteRegister), 64'd4);
    step();
    check("t2_ioack2", 64'(oIoAck), 64'd0);
    check("t2_dbgack2", 64'(oDbgAck), 64'd1);
    check("t2_reg2", 64'(oWriteRegister), 64'd5);
    check("t2_data2", 64'(oWriteData), 64'h55);
    set_req(0, 1'b0, '0, '0);
    step();
    set_req(1, 1'b0, '0, '0);
    check("t2_dbgack3", 64'(oDbgAck), 64'd0);
    check("t2_we3", 64'(oRegWrite), 64'd0);

    // T3 / T5: starvation stall, without and with a CPU violation
    run_starve(1'b0);
    run_starve(1'b1);
    do_reset();
    check("t5_err_cleared", 64'(oErr), 64'd0);

    // T4: IO write to register 0 is acked but not forwarded
    set_req(0, 1'b1, 5'd0, 32'hFFFF);
    step();
    check("t4_ack", 64'(oIoAck), 64'd1);
    check("t4_we", 64'(oRegWrite), 64'd0);
    step();
    set_req(0, 1'b0, '0, '0);
    check("t4_ack_off", 64'(oIoAck), 64'd0);

    // T6: async reset between edges while a write and ack are showing
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'hBEEF);
    @(posedge iCLK); #1;
    check("t6_we_pre", 64'(oRegWrite), 64'd1);
    check("t6_ack_pre", 64'(oIoAck), 64'd1);
    #2 iCLR = 1'b0;
    #1;
    check("t6_we_rst", 64'(oRegWrite), 64'd0);
    check("t6_ack_rst", 64'(oIoAck), 64'd0);
    check("t6_reg_rst", 64'(oWriteRegister), 64'd0);
    check("t6_data_rst", 64'(oWriteData), 64'd0);
    @(negedge iCLK);
    iCLR = 1'b1;
    step();
    check("t6_reack", 64'(oIoAck), 64'd1);
    check("t6_rewe", 64'(oRegWrite), 64'd1);
    check("t6_rereg", 64'(oWriteRegister), 64'd7);
    check("t6_redata", 64'(oWriteData), 64'hBEEF);
    step();
    set_req(0, 1'b0, '0, '0);

    // Randomized traffic at several CPU loads, checked against the model every cycle
    do_reset();
    for (int ph = 0; ph < 5; ph++)
      for (int c = 0; c < 600; c++)
        rand_cycle((ph == 4) ? 100 : ph * 30, (ph == 4) ? 95 : 70);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
